// File: rtl/serial_adder_ctrl_if.sv
// Start/busy/done handshake and operand/result bus for the bit-serial adder.
interface serial_adder_ctrl_if #(
  parameter int WIDTH = 3
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout
  );
endinterface

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: feeds a one-bit full-adder cell LSB first,
// owns the carry flop, operand shifters and result register, and exposes
// a start/busy/done handshake. A WIDTH-bit add takes WIDTH shift cycles
// followed by a one-cycle DONE state.
module serial_adder_ctrl #(
  parameter int WIDTH = 3
) (
  input  logic               clk,
  input  logic               rst,
  serial_adder_ctrl_if.slave bus
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic logic fa_sum(input logic x, input logic y, input logic ci);
    return x ^ y ^ ci;
  endfunction

  function automatic logic fa_carry(input logic x, input logic y, input logic ci);
    return (x & y) | ((x ^ y) & ci);
  endfunction

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic [WIDTH-1:0] sum_r;
  logic             carry;
  logic             cout_r;
  logic             busy_r;
  logic             done_r;
  logic [CNT_W-1:0] cnt;
  logic             cell_s;
  logic             cell_co;
  logic [WIDTH-1:0] res_next;

  // Full-adder cell on the operand LSBs; its sum bit enters the result at the MSB
  always_comb begin
    cell_s   = fa_sum(a_sh[0], b_sh[0], carry);
    cell_co  = fa_carry(a_sh[0], b_sh[0], carry);
    res_next = (res_sh >> 1) | (WIDTH'(cell_s) << (WIDTH - 1));
  end

  // Sequencer: accept in IDLE or DONE, shift WIDTH times, publish sum/cout on the last shift
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      sum_r  <= '0;
      cout_r <= 1'b0;
      carry  <= 1'b0;
      cnt    <= '0;
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done_r <= 1'b0;
          if (bus.start) begin
            a_sh   <= bus.a;
            b_sh   <= bus.b;
            carry  <= bus.cin;
            cnt    <= '0;
            res_sh <= '0;
            busy_r <= 1'b1;
            state  <= SHIFT;
          end else begin
            state  <= IDLE;
          end
        end
        SHIFT: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          carry  <= cell_co;
          res_sh <= res_next;
          cnt    <= cnt + 1'b1;
          if (cnt == CNT_LAST) begin
            sum_r  <= res_next;
            cout_r <= cell_co;
            busy_r <= 1'b0;
            done_r <= 1'b1;
            state  <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.sum  = sum_r;
  assign bus.cout = cout_r;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Testbench for serial_adder_ctrl: directed vectors and handshake corner cases
// on a WIDTH=3 instance, exhaustive WIDTH=3 sweep, random WIDTH=1 and WIDTH=8 runs.
module tb_serial_adder_ctrl;

  logic clk;
  logic rst;

  serial_adder_ctrl_if #(.WIDTH(3)) b3 ();
  serial_adder_ctrl_if #(.WIDTH(1)) b1 ();
  serial_adder_ctrl_if #(.WIDTH(8)) b8 ();

  serial_adder_ctrl #(.WIDTH(3)) dut3 (.clk(clk), .rst(rst), .bus(b3));
  serial_adder_ctrl #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst), .bus(b1));
  serial_adder_ctrl #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(b8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  // last result the WIDTH=3 instance is expected to be holding
  logic [3:0] prev3;

  typedef struct {
    logic [2:0] a;
    logic [2:0] b;
    logic       cin;
    logic [2:0] sum;
    logic       cout;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // reference: an unsigned add widened by one bit
  function automatic logic [63:0] model(input logic [63:0] x, input logic [63:0] y, input logic c);
    return x + y + 64'(c);
  endfunction

  task automatic op3(input logic [2:0] a, input logic [2:0] b, input logic c,
                     input logic [3:0] exp, input string nm);
    int lat;
    int bcnt;
    logic held;
    @(negedge clk);
    b3.a = a; b3.b = b; b3.cin = c; b3.start = 1'b1;
    @(negedge clk);
    b3.start = 1'b0;
    lat = 1; bcnt = 0; held = 1'b1;
    while (b3.done !== 1'b1 && lat < 8) begin
      if (b3.busy === 1'b1) bcnt++;
      if ({b3.cout, b3.sum} !== prev3) held = 1'b0;
      @(negedge clk);
      lat++;
    end
    check({nm, " latency"}, 64'(lat), 64'd4);
    check({nm, " busy cycles"}, 64'(bcnt), 64'd3);
    check({nm, " hold previous"}, 64'(held), 64'd1);
    check({nm, " result"}, 64'({b3.cout, b3.sum}), 64'(exp));
    check({nm, " busy at done"}, 64'(b3.busy), 64'd0);
    prev3 = exp;
    @(negedge clk);
    check({nm, " done single"}, 64'(b3.done), 64'd0);
  endtask

  task automatic op1(input logic a, input logic b, input logic c);
    int lat;
    logic [63:0] exp;
    exp = model(64'(a), 64'(b), c);
    @(negedge clk);
    b1.a = a; b1.b = b; b1.cin = c; b1.start = 1'b1;
    @(negedge clk);
    b1.start = 1'b0;
    lat = 1;
    while (b1.done !== 1'b1 && lat < 8) begin
      @(negedge clk);
      lat++;
    end
    check("w1 latency", 64'(lat), 64'd2);
    check("w1 result", 64'({b1.cout, b1.sum}), exp);
    @(negedge clk);
  endtask

  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic c);
    int lat;
    int bcnt;
    logic [63:0] exp;
    exp = model(64'(a), 64'(b), c);
    @(negedge clk);
    b8.a = a; b8.b = b; b8.cin = c; b8.start = 1'b1;
    @(negedge clk);
    b8.start = 1'b0;
    lat = 1; bcnt = 0;
    while (b8.done !== 1'b1 && lat < 16) begin
      if (b8.busy === 1'b1) bcnt++;
      @(negedge clk);
      lat++;
    end
    check("w8 latency", 64'(lat), 64'd9);
    check("w8 busy cycles", 64'(bcnt), 64'd8);
    check("w8 result", 64'({b8.cout, b8.sum}), exp);
    @(negedge clk);
  endtask

  initial begin
    int lat;
    int bc;
    int dc;
    logic [3:0] res;

    vecs[0] = '{a: 3'd3, b: 3'd5, cin: 1'b0, sum: 3'b000, cout: 1'b1};
    vecs[1] = '{a: 3'd7, b: 3'd7, cin: 1'b1, sum: 3'b111, cout: 1'b1};
    vecs[2] = '{a: 3'd2, b: 3'd1, cin: 1'b1, sum: 3'b100, cout: 1'b0};
    vecs[3] = '{a: 3'd0, b: 3'd0, cin: 1'b0, sum: 3'b000, cout: 1'b0};
    vecs[4] = '{a: 3'd7, b: 3'd0, cin: 1'b1, sum: 3'b000, cout: 1'b1};
    vecs[5] = '{a: 3'd1, b: 3'd1, cin: 1'b0, sum: 3'b010, cout: 1'b0};

    rst = 1'b1;
    b3.start = 1'b0; b3.a = '0; b3.b = '0; b3.cin = 1'b0;
    b1.start = 1'b0; b1.a = '0; b1.b = '0; b1.cin = 1'b0;
    b8.start = 1'b0; b8.a = '0; b8.b = '0; b8.cin = 1'b0;
    repeat (3) @(negedge clk);
    check("reset busy", 64'(b3.busy), 64'd0);
    check("reset done", 64'(b3.done), 64'd0);
    check("reset sum", 64'(b3.sum), 64'd0);
    check("reset cout", 64'(b3.cout), 64'd0);
    check("reset w8 sum", 64'({b8.cout, b8.sum}), 64'd0);
    rst = 1'b0;
    prev3 = 4'd0;

    // table-driven vectors (basic add, full wrap, hold of 111/1)
    for (int i = 0; i < 6; i++)
      op3(vecs[i].a, vecs[i].b, vecs[i].cin, {vecs[i].cout, vecs[i].sum}, $sformatf("vec%0d", i));

    // start pulsed again during the second busy cycle must be ignored
    bc = 0; dc = 0; res = 4'hf;
    @(negedge clk);
    b3.a = 3'd1; b3.b = 3'd1; b3.cin = 1'b0; b3.start = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 0) b3.start = 1'b0;
      if (i == 1) begin b3.a = 3'd6; b3.start = 1'b1; end
      if (i == 2) b3.start = 1'b0;
      if (b3.busy === 1'b1) bc++;
      if (b3.done === 1'b1) begin dc++; res = {b3.cout, b3.sum}; end
    end
    check("lockout busy cycles", 64'(bc), 64'd3);
    check("lockout done count", 64'(dc), 64'd1);
    check("lockout result", 64'(res), 64'd2);
    prev3 = 4'd2;

    // back-to-back with start held high, new operands in the DONE cycle
    @(negedge clk);
    b3.a = 3'd3; b3.b = 3'd2; b3.cin = 1'b1; b3.start = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (b3.done !== 1'b1 && lat < 10);
    check("b2b first latency", 64'(lat), 64'd4);
    check("b2b first result", 64'({b3.cout, b3.sum}), 64'd6);
    b3.a = 3'd4; b3.b = 3'd4; b3.cin = 1'b0;
    @(negedge clk);
    check("b2b busy restart", 64'(b3.busy), 64'd1);
    check("b2b hold first", 64'({b3.cout, b3.sum}), 64'd6);
    b3.start = 1'b0;
    lat = 1;
    while (b3.done !== 1'b1 && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    check("b2b spacing", 64'(lat), 64'd4);
    check("b2b second result", 64'({b3.cout, b3.sum}), 64'd8);
    prev3 = 4'd8;
    @(negedge clk);
    check("b2b done single", 64'(b3.done), 64'd0);

    // reset during the second busy cycle aborts with no done pulse
    dc = 0;
    @(negedge clk);
    b3.a = 3'd5; b3.b = 3'd6; b3.cin = 1'b0; b3.start = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 0) b3.start = 1'b0;
      if (i == 1) rst = 1'b1;
      if (i == 2) begin
        check("abort busy", 64'(b3.busy), 64'd0);
        check("abort done", 64'(b3.done), 64'd0);
        check("abort sum", 64'(b3.sum), 64'd0);
        check("abort cout", 64'(b3.cout), 64'd0);
        rst = 1'b0;
      end
      if (b3.done === 1'b1) dc++;
    end
    check("abort no done", 64'(dc), 64'd0);
    prev3 = 4'd0;
    op3(3'd0, 3'd0, 1'b0, 4'd0, "after abort");

    // exhaustive WIDTH=3 sweep against the arithmetic model
    for (int i = 0; i < 128; i++) begin
      logic [2:0] ea;
      logic [2:0] eb;
      logic       ec;
      ea = 3'(i >> 4);
      eb = 3'(i >> 1);
      ec = 1'(i);
      op3(ea, eb, ec, 4'(model(64'(ea), 64'(eb), ec)), "sweep");
    end

    // random WIDTH=1 and WIDTH=8 operands, including the all-ones wrap
    for (int i = 0; i < 20; i++)
      op1(1'($urandom), 1'($urandom), 1'($urandom));
    op8(8'hff, 8'hff, 1'b1);
    for (int i = 0; i < 40; i++)
      op8(8'($urandom), 8'($urandom), 1'($urandom));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
